obstacle_scroller: RTL and testbench
====================================

Name: obstacle_scroller

Overview:
Parametrised multi-object scroller for the 160x120 VGA adapter.
- Maintains NUM_OBJ independent obstacles.
- Spawns each obstacle at the right edge with a pseudo-random row, moves all obstacles left one pixel per frame tick, and retires them at the left edge.
- Emits one pixel write per cycle (x, y, colour, plot) straight into the VGA adapter's write port: erase pass at old positions, then draw pass at new positions.
- Successor to the single-object animation datapath/control pair; sits between the game FSM (enable) and vga_adapter.

Parameters:
- NUM_OBJ, 4, number of obstacle slots (1..8).
- OBJ_W, 4, obstacle width in pixels.
- OBJ_H, 4, obstacle height in pixels.
- SCREEN_W, 160, visible columns.
- SCREEN_H, 120, visible rows.
- TICK_DIV, 833333, clock cycles per frame tick (60 Hz at 50 MHz).
- SPAWN_GAP, 40, minimum frame ticks between spawns.
- LFSR_SEED, 10'b0010010100, non-zero LFSR seed.
- OBJ_COLOUR, 3'b010, draw colour.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clock, input, 1, system clock (CLOCK_50 domain).
- resetn, input, 1, asynchronous active-low reset.
- enable, input, 1, run animation; when low, no new frames start.
- x_out, output, 8, pixel column to adapter.
- y_out, output, 7, pixel row to adapter.
- colour_out, output, 3, pixel colour to adapter.
- plot, output, 1, pixel write strobe; one pixel per cycle while high.
- frame_done, output, 1, one-cycle pulse when a frame update completes.
- busy, output, 1, high from frame start until the frame_done cycle inclusive.
- active_mask, output, NUM_OBJ, bit i = slot i occupied (for collision logic).

Behaviour:
Reset (async, resetn low):
- All slots inactive; obj_x = 0, obj_y = 0.
- Tick counter = TICK_DIV-1; gap counter = 0; LFSR = LFSR_SEED.
- FSM in S_IDLE.
- Outputs: x_out, y_out, colour_out, plot, frame_done, busy, active_mask all 0.
- Reset mid-frame abandons the frame immediately; no further plot.

Tick generation:
- Down-counter decrements every cycle while enable = 1; holds while enable = 0.
- At 0 it reloads TICK_DIV-1 and asserts tick for one cycle.
- A tick while busy sets a pending flag. Multiple pending ticks coalesce to one.
- The pending flag is consumed on the next return to S_IDLE.

LFSR:
- 10-bit Fibonacci, taps x^10 + x^7 + 1, advances every clock.
- Spawn row: r = lfsr[6:0]. If r > SCREEN_H-OBJ_H, use r - (SCREEN_H-OBJ_H+1). Result lies in [0, SCREEN_H-OBJ_H].

FSM (S_IDLE -> S_ERASE -> S_UPDATE -> S_DRAW -> S_DONE -> S_IDLE):
- S_IDLE: on (tick | pending) && enable, go to S_ERASE; busy rises in that cycle.
- S_ERASE: walk slots 0..NUM_OBJ-1, skipping inactive slots in zero cycles. For each active slot, raster OBJ_W*OBJ_H pixels row-major (dx fastest) with colour BG_COLOUR and plot = 1, one pixel per cycle.
- S_UPDATE: single cycle. Every active slot with obj_x == 0 deactivates. Every other active slot gets obj_x -= 1. Then:
  - gap counter decrements if non-zero.
  - If gap counter == 0 and a free slot exists, the lowest-index free slot spawns with obj_x = SCREEN_W-OBJ_W and obj_y = the LFSR row sampled this cycle, and the gap counter reloads SPAWN_GAP.
  - A slot retired this cycle cannot respawn in the same cycle.
- S_DRAW: same raster as erase, using OBJ_COLOUR and updated positions.
- S_DONE: frame_done = 1 for one cycle; then S_IDLE.
- Frame length: (A_old + A_new) * OBJ_W * OBJ_H + 2 cycles, where A = number of active slots.

Outputs and arithmetic:
- x_out = obj_x + dx and y_out = obj_y + dy, 8/7-bit, never exceed SCREEN_W-1 / SCREEN_H-1 by construction.
- plot is low outside S_ERASE/S_DRAW pixel cycles; x_out, y_out and colour_out hold their last values.
- active_mask updates only in S_UPDATE.
- enable falling mid-frame: the current frame completes; pending is cleared.

Decomposition:
- Package scroller_pkg: FSM state enum (S_IDLE, S_ERASE, S_UPDATE, S_DRAW, S_DONE), screen constants, colour constants.
- One sub-module, spawn_lfsr: 10-bit LFSR with seed parameter and row-range reduction.
- Tick divider and slot arrays are inline.

Test Plan:
Sim parameters: NUM_OBJ=2, OBJ_W=2, OBJ_H=2, TICK_DIV=4, SPAWN_GAP=3.
1. Reset, then enable=1 -> first tick spawns slot0 at x=158. Draw emits 4 plots (158,y),(159,y),(158,y+1),(159,y+1) in colour 010. active_mask=01; frame_done pulses once.
2. Next tick -> erase plots 4 pixels at x=158 in colour 000, then draw at x=157. No spawn (gap=2). Frame length = 8+2 = 10 cycles.
3. Run to 3 ticks after the first spawn -> slot1 spawns, active_mask=11. Every spawned y is in [0,116]. Force LFSR row 127 -> y=10.
4. Preload slot0 at x=0 -> erase at x=0, slot0 retired, no draw for slot0, active_mask bit0 falls the cycle after S_UPDATE.
5. Hold TICK_DIV small so 2 ticks land during busy -> exactly one extra frame follows; no frame is lost or duplicated beyond one.
6. Assert resetn low mid-draw -> plot drops asynchronously the same cycle; all outputs 0; after release, the first frame follows scenario 1.

Source files
------------

// File: rtl/scroller_pkg.sv
// scroller_pkg: shared FSM states, screen geometry and colours
// for the multi-object obstacle scroller.
package scroller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_UPDATE,
    S_DRAW,
    S_DONE
  } state_t;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  localparam int MAX_OBJ = 8;
  localparam logic [3:0] NO_SLOT = 4'd8;

  localparam logic [C_W-1:0] COL_OBJ = 3'b010;
  localparam logic [C_W-1:0] COL_BG  = 3'b000;

  localparam logic [9:0] SEED_DEF = 10'b0010010100;

  // lowest set bit of mask at or above from; NO_SLOT if none
  function automatic logic [3:0] next_slot(
    input logic [MAX_OBJ-1:0] mask,
    input logic [3:0]         from
  );
    logic [3:0] r;
    r = NO_SLOT;
    for (int i = MAX_OBJ - 1; i >= 0; i--)
      if (mask[i] && (4'(i) >= from))
        r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// spawn_lfsr: free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1)
// folded into a legal spawn row in [0, ROW_MAX].
module spawn_lfsr
  import scroller_pkg::*;
#(
  parameter logic [9:0] SEED    = SEED_DEF,
  parameter int         ROW_MAX = 116
) (
  input  logic           clock,
  input  logic           resetn,
  output logic [Y_W-1:0] row
);

  localparam logic [Y_W-1:0] RMAX = Y_W'(ROW_MAX);
  localparam logic [Y_W-1:0] WRAP = Y_W'(ROW_MAX + 1);

  logic [9:0]     lfsr;
  logic [Y_W-1:0] raw;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      lfsr <= SEED;
    else
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  end

  assign raw = lfsr[6:0];
  assign row = (raw > RMAX) ? raw - WRAP : raw;

endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: NUM_OBJ obstacles scrolled left once per frame tick,
// streamed to the VGA adapter as an erase pass followed by a draw pass.
module obstacle_scroller
  import scroller_pkg::*;
#(
  parameter int             NUM_OBJ    = 4,
  parameter int             OBJ_W      = 4,
  parameter int             OBJ_H      = 4,
  parameter int             SCREEN_W   = SCR_W,
  parameter int             SCREEN_H   = SCR_H,
  parameter int             TICK_DIV   = 833333,
  parameter int             SPAWN_GAP  = 40,
  parameter logic [9:0]     LFSR_SEED  = SEED_DEF,
  parameter logic [C_W-1:0] OBJ_COLOUR = COL_OBJ,
  parameter logic [C_W-1:0] BG_COLOUR  = COL_BG
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [C_W-1:0]     colour_out,
  output logic               plot,
  output logic               frame_done,
  output logic               busy,
  output logic [NUM_OBJ-1:0] active_mask
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;

  localparam logic [TW-1:0]  TICK_TOP = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0]  GAP_TOP  = GW'(SPAWN_GAP);
  localparam logic [X_W-1:0] X_SPAWN  = X_W'(SCREEN_W - OBJ_W);
  localparam logic [X_W-1:0] DX_TOP   = X_W'(OBJ_W - 1);
  localparam logic [Y_W-1:0] DY_TOP   = Y_W'(OBJ_H - 1);

  state_t state_q, state_d;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          pending;

  logic [GW-1:0]      gap_q, gap_d;
  logic [NUM_OBJ-1:0] act_q, act_d;
  logic [X_W-1:0]     obj_x [NUM_OBJ];
  logic [X_W-1:0]     x_d   [NUM_OBJ];
  logic [Y_W-1:0]     obj_y [NUM_OBJ];
  logic [Y_W-1:0]     y_d   [NUM_OBJ];
  logic               spawned;

  logic [3:0]     cur_q, cur_d;
  logic [3:0]     first_old, first_new, nxt;
  logic [X_W-1:0] dx_q, dx_d;
  logic [Y_W-1:0] dy_q, dy_d;

  logic [Y_W-1:0] row;
  logic           pix;
  logic [X_W-1:0] px, x_h;
  logic [Y_W-1:0] py, y_h;
  logic [C_W-1:0] pc, c_h;

  spawn_lfsr #(
    .SEED    (LFSR_SEED),
    .ROW_MAX (SCREEN_H - OBJ_H)
  ) u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .row    (row)
  );

  assign tick = enable && (tick_cnt == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      tick_cnt <= TICK_TOP;
    else if (enable)
      tick_cnt <= (tick_cnt == '0) ? TICK_TOP : tick_cnt - 1'b1;
  end

  // ticks landing mid-frame collapse into a single replay
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      pending <= 1'b0;
    else if (!enable)
      pending <= 1'b0;
    else if (state_q == S_IDLE)
      pending <= 1'b0;
    else if (tick)
      pending <= 1'b1;
  end

  always_comb begin
    act_d   = act_q;
    gap_d   = gap_q;
    spawned = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      x_d[i] = obj_x[i];
      y_d[i] = obj_y[i];
    end
    if (state_q == S_UPDATE) begin
      for (int i = 0; i < NUM_OBJ; i++)
        if (act_q[i]) begin
          if (obj_x[i] == '0)
            act_d[i] = 1'b0;
          else
            x_d[i] = obj_x[i] - 1'b1;
        end
      if (gap_q != '0)
        gap_d = gap_q - 1'b1;
      // free means free before this update, so retirees wait a frame
      if (gap_d == '0)
        for (int i = 0; i < NUM_OBJ; i++)
          if (!act_q[i] && !spawned) begin
            spawned  = 1'b1;
            act_d[i] = 1'b1;
            x_d[i]   = X_SPAWN;
            y_d[i]   = row;
            gap_d    = GAP_TOP;
          end
    end
  end

  assign first_old = next_slot(MAX_OBJ'(act_q), 4'd0);
  assign first_new = next_slot(MAX_OBJ'(act_d), 4'd0);
  assign nxt       = next_slot(MAX_OBJ'(act_q), cur_q + 4'd1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    unique case (state_q)
      S_IDLE: begin
        if ((tick || pending) && enable) begin
          cur_d   = first_old;
          dx_d    = '0;
          dy_d    = '0;
          state_d = (first_old == NO_SLOT) ? S_UPDATE : S_ERASE;
        end
      end
      S_ERASE, S_DRAW: begin
        if (dx_q != DX_TOP) begin
          dx_d = dx_q + 1'b1;
        end else begin
          dx_d = '0;
          if (dy_q != DY_TOP) begin
            dy_d = dy_q + 1'b1;
          end else begin
            dy_d  = '0;
            cur_d = nxt;
            if (nxt == NO_SLOT)
              state_d = (state_q == S_ERASE) ? S_UPDATE : S_DONE;
          end
        end
      end
      S_UPDATE: begin
        cur_d   = first_new;
        dx_d    = '0;
        dy_d    = '0;
        state_d = (first_new == NO_SLOT) ? S_DONE : S_DRAW;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    px = '0;
    py = '0;
    for (int i = 0; i < NUM_OBJ; i++)
      if (cur_q == 4'(i)) begin
        px = obj_x[i] + dx_q;
        py = obj_y[i] + dy_q;
      end
  end

  assign pix = (state_q == S_ERASE) || (state_q == S_DRAW);
  assign pc  = (state_q == S_DRAW) ? OBJ_COLOUR : BG_COLOUR;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      gap_q   <= '0;
      act_q   <= '0;
      x_h     <= '0;
      y_h     <= '0;
      c_h     <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        obj_x[i] <= '0;
        obj_y[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      gap_q   <= gap_d;
      act_q   <= act_d;
      for (int i = 0; i < NUM_OBJ; i++) begin
        obj_x[i] <= x_d[i];
        obj_y[i] <= y_d[i];
      end
      if (pix) begin
        x_h <= px;
        y_h <= py;
        c_h <= pc;
      end
    end
  end

  assign plot        = pix;
  assign x_out       = pix ? px : x_h;
  assign y_out       = pix ? py : y_h;
  assign colour_out  = pix ? pc : c_h;
  assign frame_done  = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign active_mask = act_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// tb_obstacle_scroller: random enable/reset stimulus against an
// event-queue model of frames, spawns, scrolling and retirement.
module tb_obstacle_scroller;

  localparam int NO  = 2;
  localparam int OW  = 2;
  localparam int OH  = 2;
  localparam int SW  = 160;
  localparam int SH  = 120;
  localparam int TD  = 4;
  localparam int GAP = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       frame_done;
  logic       busy;
  logic [1:0] active_mask;

  obstacle_scroller #(
    .NUM_OBJ   (NO),
    .OBJ_W     (OW),
    .OBJ_H     (OH),
    .TICK_DIV  (TD),
    .SPAWN_GAP (GAP)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .x_out       (x_out),
    .y_out       (y_out),
    .colour_out  (colour_out),
    .plot        (plot),
    .frame_done  (frame_done),
    .busy        (busy),
    .active_mask (active_mask)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit plot;
    bit draw;
    int x;
    int y;
    bit upd;
    bit done;
  } ev_t;

  ev_t        q[$];
  int         mx[NO];
  int         my[NO];
  bit         ma[NO];
  int         gapc;
  int         tc;
  bit         pend;
  logic [9:0] lf;
  int         hx, hy, hc;
  int         frames = 0;
  int         dut_frames = 0;
  int         left_erase = 0;
  bit         found;

  function automatic int spawn_row(input logic [9:0] l);
    int r;
    r = int'(l[6:0]);
    return (r > SH - OH) ? r - (SH - OH + 1) : r;
  endfunction

  task automatic push_raster(input bit draw);
    ev_t e;
    for (int s = 0; s < NO; s++)
      if (ma[s])
        for (int yy = 0; yy < OH; yy++)
          for (int xx = 0; xx < OW; xx++) begin
            e = '{default: 0};
            e.plot = 1'b1;
            e.draw = draw;
            e.x = mx[s] + xx;
            e.y = my[s] + yy;
            q.push_back(e);
          end
  endtask

  task automatic model_reset();
    q.delete();
    for (int s = 0; s < NO; s++) begin
      mx[s] = 0;
      my[s] = 0;
      ma[s] = 1'b0;
    end
    gapc = 0;
    tc = TD - 1;
    pend = 1'b0;
    lf = 10'b0010010100;
    hx = 0;
    hy = 0;
    hc = 0;
  endtask

  task automatic do_update();
    bit  old[NO];
    bit  took;
    ev_t e;
    took = 1'b0;
    for (int s = 0; s < NO; s++) old[s] = ma[s];
    for (int s = 0; s < NO; s++)
      if (old[s]) begin
        if (mx[s] == 0) ma[s] = 1'b0;
        else mx[s] = mx[s] - 1;
      end
    if (gapc > 0) gapc = gapc - 1;
    if (gapc == 0)
      for (int s = 0; s < NO; s++)
        if (!old[s] && !took) begin
          took = 1'b1;
          ma[s] = 1'b1;
          mx[s] = SW - OW;
          my[s] = spawn_row(lf);
          gapc = GAP;
        end
    push_raster(1'b1);
    e = '{default: 0};
    e.done = 1'b1;
    q.push_back(e);
  endtask

  task automatic model_cycle();
    ev_t e;
    bit  bz;
    bit  tk;
    int  em;
    bz = (q.size() != 0);
    em = 0;
    for (int s = 0; s < NO; s++)
      if (ma[s]) em = em | (1 << s);
    if (bz) e = q.pop_front();
    else e = '{default: 0};
    chk("busy", 32'(busy), 32'(bz));
    chk("plot", 32'(plot), 32'(e.plot));
    chk("frame_done", 32'(frame_done), 32'(e.done));
    chk("active_mask", 32'(active_mask), em);
    if (e.plot) begin
      hx = e.x;
      hy = e.y;
      hc = e.draw ? 2 : 0;
    end
    chk("x_out", 32'(x_out), hx);
    chk("y_out", 32'(y_out), hy);
    chk("colour_out", 32'(colour_out), hc);
    if (plot) chk("y_range", 32'(y_out <= 7'(SH - 1)), 1);
    if (plot && colour_out == 3'b000 && x_out == 8'd0)
      left_erase++;
    if (frame_done) dut_frames++;
    if (e.upd) do_update();
    if (e.done) frames++;
    tk = enable && (tc == 0);
    if (!bz && enable && (tk || pend)) begin
      push_raster(1'b0);
      e = '{default: 0};
      e.upd = 1'b1;
      q.push_back(e);
    end
    if (!enable) pend = 1'b0;
    else if (!bz) pend = 1'b0;
    else if (tk) pend = 1'b1;
    if (enable) tc = (tc == 0) ? TD - 1 : tc - 1;
    lf = {lf[8:0], lf[9] ^ lf[6]};
  endtask

  always @(negedge clock) begin
    if (!resetn) begin
      chk("rst_plot", 32'(plot), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_mask", 32'(active_mask), 0);
      chk("rst_xyc", {x_out, y_out, colour_out}, 0);
      model_reset();
    end else begin
      model_cycle();
    end
  end

  task automatic run_random(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #1;
      if (enable) begin
        if ($urandom_range(0, 99) < 2) enable = 1'b0;
      end else if ($urandom_range(0, 99) < 25) begin
        enable = 1'b1;
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    enable = 1'b1;
    run_random(6000);
    enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clock);
      #1;
      if (plot && colour_out == 3'b010) found = 1'b1;
    end
    chk("reach_draw", 32'(found), 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_plot", 32'(plot), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_mask", 32'(active_mask), 0);
    chk("async_xyc", {x_out, y_out, colour_out}, 0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    enable = 1'b1;
    run_random(800);
    @(negedge clock);
    chk("left_edge_erase", 32'(left_erase > 0), 1);
    chk("frames_seen", dut_frames, frames);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
